regfile_write_arbiter: RTL
==========================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning entries per requester FIFO (power of two, >=2).
REQ-002 SHALL have parameter DW, default 128, meaning write-data width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port a_valid, input, 1, requester A (scalar writeback) offers a write.
REQ-006 SHALL have port a_ready, output, 1, requester A's FIFO can accept.
REQ-007 SHALL have ports a_addr, input, 4, destination register; a_data, input, DW, write data; a_vec, input, 1, selects the vector file (1) or scalar file (0).
REQ-008 SHALL have ports b_valid/b_ready/b_addr/b_data/b_vec, identical to REQ-005..007, for requester B (AES/vector unit writeback).
REQ-009 SHALL have port wr_addr, output, 4, shared register-file write address.
REQ-010 SHALL have port wr_data, output, DW, shared register-file write data.
REQ-011 SHALL have port reg_write, output, 1, scalar-file write enable.
REQ-012 SHALL have port vreg_write, output, 1, vector-file write enable.
REQ-013 SHALL have port busy, output, 1, high while either FIFO is non-empty or a write is being driven.

Function
REQ-014 A handshake SHALL be accepted on a rising edge where x_valid && x_ready; the {addr,data,vec} triple is pushed into that requester's FIFO.
REQ-015 x_ready SHALL be high iff that FIFO is not full; it SHALL depend only on registered state, with no pass-through while full.
REQ-016 Each cycle the arbiter SHALL pop at most one FIFO head and register it onto wr_addr/wr_data/reg_write/vreg_write for exactly one cycle.
REQ-017 Minimum latency SHALL be 1 cycle: an entry accepted at edge N into an empty FIFO with no competitor drives the write port during cycle N+1.
REQ-018 Exactly one of reg_write/vreg_write SHALL be high per issued write, per the stored vec bit; both SHALL be low in idle cycles.
REQ-019 In idle cycles wr_addr and wr_data SHALL hold their previous values.
REQ-020 When only one FIFO is non-empty, its head SHALL be granted.
REQ-021 When both FIFOs are non-empty, the head named by the round-robin pointer SHALL be granted, and the pointer SHALL then point to the other requester.
REQ-022 After reset the pointer SHALL favour A.
REQ-023 A push and a pop on the same FIFO in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-024 Each FIFO SHALL use DEPTH-entry storage with wrap-around read/write pointers plus an occupancy count of width clog2(DEPTH)+1.
REQ-025 Per-requester order SHALL be preserved; ordering between A and B is set only by grant order (cross-requester write-after-write is the issuer's responsibility).
REQ-026 Sustained valid on both ports SHALL yield alternating A,B,A,B writes at one write per cycle, with no starvation.

Reset
REQ-027 Asserting rst at any time, including mid-burst, SHALL immediately empty both FIFOs, discard pending entries, set the pointer to A, and drive reg_write=0, vreg_write=0, wr_addr=0, wr_data=0, busy=0.
REQ-028 a_ready and b_ready SHALL be 1 while in reset, but no handshake SHALL be accepted while rst is high.
REQ-029 The first acceptance SHALL occur at the first rising edge after rst deasserts.

Structure
REQ-030 The write-request struct {addr[3:0], data[DW-1:0], vec} and the constant NUM_REQ=2 SHALL live in the shared pipeline package.
REQ-031 The per-requester FIFO SHALL be one sub-module, wr_req_fifo, instantiated twice; arbitration and output registers SHALL live in the top module.

Verification
REQ-032 Single write: A pushes addr=3, data=0x00112233_44556677_8899AABB_CCDDEEFF, vec=1 at edge 5 -> vreg_write=1, wr_addr=3, and that data in cycle 6 only; reg_write=0 throughout.
REQ-033 Contention: A (addr=1, vec=0) and B (addr=2, vec=1) both push at edge 2 after reset -> A writes in cycle 3 and B in cycle 4; a repeat at edge 10 gives B in cycle 11, then A.
REQ-034 Backpressure: B pushes 4 entries back-to-back while A is held valid continuously -> b_ready drops after 2 outstanding, no entry is lost or duplicated, and B's writes emerge in push order.
REQ-035 Simultaneous push/pop: with DEPTH=2, A is full and a grant occurs -> a_ready rises the next cycle; a push in that cycle is accepted and the count stays at 2.
REQ-036 Reset mid-burst: rst is asserted for 1 cycle with 2+2 entries pending -> write enables are 0 immediately, busy=0, and no stale write appears after release.
REQ-037 Random stress: 10k cycles of random valids against a scoreboard -> every accepted entry is written exactly once and per-requester order is preserved.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared writeback-pipeline types: the register-file write request and the
// requester selector used by the round-robin arbiter.
package regfile_write_arbiter_pkg;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 4;
    // Widest write data carried through the request FIFOs; DW must not exceed it.
    localparam int MAX_DW  = 128;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [MAX_DW-1:0] data;
        logic              vec;
    } wr_req_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_sel_t;

endpackage

// File: rtl/regfile_write_arbiter_fifo.sv
// Per-requester write-request FIFO: DEPTH entries, wrap-around pointers and an
// occupancy count. Full/empty come straight from the registered count.
module wr_req_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_push,
    input  wr_req_t i_req,
    input  logic    i_pop,
    output wr_req_t o_head,
    output logic    o_empty,
    output logic    o_full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wr_req_t        r_mem [DEPTH];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    logic           w_push;
    logic           w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rptr];

    // Pointer and occupancy tracking; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are don't-care once the count says they are gone.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_req;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges scalar (A) and vector/AES (B) writeback streams onto one shared
// register-file write port, one write per cycle, round-robin under contention.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DW    = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [3:0]    a_addr,
    input  logic [DW-1:0] a_data,
    input  logic          a_vec,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [3:0]    b_addr,
    input  logic [DW-1:0] b_data,
    input  logic          b_vec,
    output logic [3:0]    wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          reg_write,
    output logic          vreg_write,
    output logic          busy
);
    wr_req_t  w_a_req, w_b_req, w_a_head, w_b_head, w_sel_head;
    logic     w_a_empty, w_a_full, w_b_empty, w_b_full;
    logic     w_a_pop, w_b_pop, w_grant_valid;
    req_sel_t w_grant;
    req_sel_t r_rr_ptr;

    logic [3:0]    r_wr_addr;
    logic [DW-1:0] r_wr_data;
    logic          r_reg_write;
    logic          r_vreg_write;

    assign w_a_req = {a_addr, MAX_DW'(a_data), a_vec};
    assign w_b_req = {b_addr, MAX_DW'(b_data), b_vec};
    assign a_ready = !w_a_full;
    assign b_ready = !w_b_full;

    wr_req_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk    (clk),
        .rst    (rst),
        .i_push (a_valid),
        .i_req  (w_a_req),
        .i_pop  (w_a_pop),
        .o_head (w_a_head),
        .o_empty(w_a_empty),
        .o_full (w_a_full)
    );

    wr_req_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk    (clk),
        .rst    (rst),
        .i_push (b_valid),
        .i_req  (w_b_req),
        .i_pop  (w_b_pop),
        .o_head (w_b_head),
        .o_empty(w_b_empty),
        .o_full (w_b_full)
    );

    // Grant selection: a lone non-empty FIFO wins, otherwise the round-robin pointer decides.
    always_comb begin
        w_grant       = r_rr_ptr;
        w_grant_valid = 1'b0;
        if (!w_a_empty && !w_b_empty) begin
            w_grant       = r_rr_ptr;
            w_grant_valid = 1'b1;
        end else if (!w_a_empty) begin
            w_grant       = REQ_A;
            w_grant_valid = 1'b1;
        end else if (!w_b_empty) begin
            w_grant       = REQ_B;
            w_grant_valid = 1'b1;
        end
        w_a_pop    = w_grant_valid && (w_grant == REQ_A);
        w_b_pop    = w_grant_valid && (w_grant == REQ_B);
        w_sel_head = (w_grant == REQ_A) ? w_a_head : w_b_head;
    end

    // Round-robin pointer only advances when both requesters actually competed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= REQ_A;
        end else if (!w_a_empty && !w_b_empty) begin
            r_rr_ptr <= (w_grant == REQ_A) ? REQ_B : REQ_A;
        end
    end

    // Write-port register: enables pulse for one cycle, address/data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_reg_write  <= 1'b0;
            r_vreg_write <= 1'b0;
        end else begin
            r_reg_write  <= w_grant_valid && !w_sel_head.vec;
            r_vreg_write <= w_grant_valid && w_sel_head.vec;
            if (w_grant_valid) begin
                r_wr_addr <= w_sel_head.addr;
                r_wr_data <= w_sel_head.data[DW-1:0];
            end
        end
    end

    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign reg_write  = r_reg_write;
    assign vreg_write = r_vreg_write;
    assign busy       = !w_a_empty || !w_b_empty || r_reg_write || r_vreg_write;

endmodule
